step_sequencer: RTL
===================

# step_sequencer

Motion-profile controller for the stepper driver. It accepts move commands (step count, direction, cruise period) over a valid/ready handshake and emits one-cycle step strobes with a linear acceleration/deceleration ramp. It also supports a graceful abort. It sits between the button/command logic and the phase-sequencing stepper driver, replacing the free-running frequency divider as the source of step timing.

## Interface
Parameters:
- CNT_W, 28: period/timer width in clk cycles.
- STEP_W, 16: step-count width.
- START_PERIOD, 240000: first and last step interval in cycles (100 Hz at 24 MHz).
- ACCEL_DELTA, 2400: period change per step while ramping.

Ports (one clock, `clk`; reset `rst` is asynchronous, active-high):
- clk  in  1  system clock (24 MHz).
- rst  in  1  async active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_steps  in  STEP_W  steps to move.
- cmd_dir  in  1  direction for the move.
- cmd_period_min  in  CNT_W  cruise interval in cycles; clamped to ≥2 and ≤START_PERIOD.
- abort  in  1  level; request ramp-down.
- step_pulse  out  1  one-cycle step strobe to the driver.
- dir_out  out  1  direction latched at accept.
- busy  out  1  move in progress.
- done  out  1  one-cycle completion strobe.
- steps_left  out  STEP_W  remaining steps.

## Operation
- States:
  - IDLE: on accept with steps>0, go to ACCEL; if steps==0, go to DONE.
  - ACCEL: go to CRUISE when the period reaches the clamped minimum.
  - CRUISE: normal-rate stepping.
  - DECEL: ramp-down stepping.
  - DONE: lasts 1 cycle, then IDLE.
- Accept = cmd_valid && cmd_ready at a clk edge. On accept:
  - Latch dir_out and the clamped period_min.
  - Set steps_left=cmd_steps, period=START_PERIOD, accel_cnt=0.
  - Load the timer with period-1.
- Timer counts down once per cycle. At 0 it emits step_pulse and reloads with the updated period-1.
- Per step, in priority order, with rem = steps_left-1:
  1. If rem==0, go to DONE.
  2. Else if rem ≤ accel_cnt, state=DECEL, period=min(period+ACCEL_DELTA, START_PERIOD), accel_cnt-=1 (saturate at 0).
  3. Else if ACCEL, period=max(period-ACCEL_DELTA, period_min), accel_cnt+=1, and go to CRUISE if the new period==period_min.
  4. CRUISE keeps the period unchanged.
- If period_min==START_PERIOD, the block enters CRUISE at accept.
- Abort (sampled in ACCEL/CRUISE/DECEL): steps_left=min(steps_left, accel_cnt+1). The normal rules then ramp down. Abort in IDLE/DONE is ignored.
- Abort on the same cycle as the final step: the step completes, then DONE.
- Period arithmetic is in CNT_W. Subtraction saturates at period_min with no underflow; addition saturates at START_PERIOD.
- cmd_dir and cmd_period_min changes during a move have no effect.

## Timing
- Reset values: cmd_ready=1, busy=0, done=0, step_pulse=0, dir_out=0, steps_left=0. Reset takes effect immediately, mid-move included; the timer and accel_cnt clear.
- Accept at edge T: busy=1 and cmd_ready=0 from T+1, and the first step_pulse occurs at cycle T+START_PERIOD.
- Consecutive step_pulses are exactly one period apart, where period is the value after the previous step's update.
- done asserts in the cycle after the final step_pulse, with busy=0 and cmd_ready=1 one cycle later.
- For steps==0, done asserts at T+1 with no step_pulse.
- cmd_valid while busy: no effect, no queueing.

## Structure
- Shared header: state encodings and default constants (START_PERIOD, ACCEL_DELTA).
- One sub-module, `step_timer`: a loadable CNT_W down-counter with a terminal-count strobe.
- The FSM, ramp arithmetic and step counting live in `step_sequencer`.

## Test plan
Bench parameters are START_PERIOD=100, ACCEL_DELTA=20, period_min=40.
- steps=0 -> done at T+1, no step_pulse, busy never high.
- steps=10 -> step intervals 100,80,60,40,40,40,40,60,80,100; done one cycle after the 10th pulse.
- steps=4 (triangle) -> intervals 100,80,60,80; the block never enters CRUISE.
- steps=100, abort asserted after the 5th pulse -> intervals after abort 40,60,80,100, 9 pulses total, then done.
- cmd_valid held during a move with different steps/dir -> ignored; dir_out stays as latched and cmd_ready stays 0.
- rst asserted mid-CRUISE -> all outputs at reset values immediately; a new command afterwards starts with a 100-cycle first interval.

Source files
------------

// File: rtl/step_sequencer_pkg.sv
// rtl/step_sequencer_pkg.sv - shared state encodings and default constants for the step sequencer
package step_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCEL  = 3'd1,
        ST_CRUISE = 3'd2,
        ST_DECEL  = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    localparam int DEF_CNT_W        = 28;
    localparam int DEF_STEP_W       = 16;
    localparam int DEF_START_PERIOD = 240000;
    localparam int DEF_ACCEL_DELTA  = 2400;

endpackage

// File: rtl/step_sequencer_if.sv
// rtl/step_sequencer_if.sv - move-command valid/ready interface
interface step_sequencer_if
    import step_sequencer_pkg::*;
#(
    parameter int CNT_W  = DEF_CNT_W,
    parameter int STEP_W = DEF_STEP_W
);

    logic              cmd_valid;
    logic              cmd_ready;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_dir;
    logic [CNT_W-1:0]  cmd_period_min;

    modport master (
        output cmd_valid,
        output cmd_steps,
        output cmd_dir,
        output cmd_period_min,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_steps,
        input  cmd_dir,
        input  cmd_period_min,
        output cmd_ready
    );

endinterface

// File: rtl/step_sequencer_timer.sv
// rtl/step_sequencer_timer.sv - loadable down-counter with terminal-count strobe (module step_timer)
module step_timer
    import step_sequencer_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Holds at zero once expired so the terminal count stays visible until reloaded.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/step_sequencer.sv
// rtl/step_sequencer.sv - move FSM with linear accel/decel ramp, step counting and graceful abort
module step_sequencer
    import step_sequencer_pkg::*;
#(
    parameter int CNT_W        = DEF_CNT_W,
    parameter int STEP_W       = DEF_STEP_W,
    parameter int START_PERIOD = DEF_START_PERIOD,
    parameter int ACCEL_DELTA  = DEF_ACCEL_DELTA
) (
    input  logic              clk,
    input  logic              rst,
    step_sequencer_if.slave   cmd,
    input  logic              abort,
    output logic              step_pulse,
    output logic              dir_out,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] steps_left
);

    localparam logic [CNT_W-1:0] START_P = CNT_W'(START_PERIOD);
    localparam logic [CNT_W-1:0] DELTA   = CNT_W'(ACCEL_DELTA);
    localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(2);

    state_e            state_q, state_d;
    logic              dir_q, dir_d;
    logic [CNT_W-1:0]  pmin_q, pmin_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [STEP_W-1:0] accel_q, accel_d;
    logic [STEP_W-1:0] steps_q, steps_d;

    logic              running;
    logic              step;
    logic              timer_load;
    logic [CNT_W-1:0]  timer_val;
    logic              timer_tc;
    logic [CNT_W-1:0]  pmin_in;
    logic [STEP_W-1:0] rem;
    logic [STEP_W:0]   abort_lim;

    step_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (timer_load),
        .load_val_i (timer_val),
        .tc_o       (timer_tc)
    );

    assign running = (state_q == ST_ACCEL) || (state_q == ST_CRUISE) || (state_q == ST_DECEL);
    assign step    = running && timer_tc;
    assign rem     = steps_q - STEP_W'(1);

    always_comb begin
        pmin_in = cmd.cmd_period_min;
        if (cmd.cmd_period_min < MIN_P) begin
            pmin_in = MIN_P;
        end else if (cmd.cmd_period_min > START_P) begin
            pmin_in = START_P;
        end
    end

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        pmin_d     = pmin_q;
        period_d   = period_q;
        accel_d    = accel_q;
        steps_d    = steps_q;
        timer_load = 1'b0;
        timer_val  = '0;
        abort_lim  = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd.cmd_valid) begin
                    dir_d      = cmd.cmd_dir;
                    pmin_d     = pmin_in;
                    steps_d    = cmd.cmd_steps;
                    period_d   = START_P;
                    accel_d    = '0;
                    timer_load = 1'b1;
                    if (cmd.cmd_steps == '0) begin
                        state_d = ST_DONE;
                    end else if (pmin_in == START_P) begin
                        state_d = ST_CRUISE;
                    end else begin
                        state_d = ST_ACCEL;
                    end
                end
            end
            ST_ACCEL, ST_CRUISE, ST_DECEL: begin
                if (step) begin
                    timer_load = 1'b1;
                    steps_d    = rem;
                    if (rem == '0) begin
                        state_d = ST_DONE;
                    end else if (rem <= accel_q) begin
                        // Remaining steps just cover the ramp-down: start braking.
                        state_d  = ST_DECEL;
                        period_d = (START_P - period_q <= DELTA) ? START_P : period_q + DELTA;
                        accel_d  = (accel_q == '0) ? '0 : accel_q - STEP_W'(1);
                    end else if (state_q == ST_ACCEL) begin
                        period_d = (period_q - pmin_q <= DELTA) ? pmin_q : period_q - DELTA;
                        accel_d  = accel_q + STEP_W'(1);
                        if (period_d == pmin_q) begin
                            state_d = ST_CRUISE;
                        end
                    end
                end
                // Abort trims the move to what the ramp-down needs; the step rules do the rest.
                if (abort && (state_d != ST_DONE)) begin
                    abort_lim = {1'b0, accel_d} + (STEP_W+1)'(1);
                    if ({1'b0, steps_d} > abort_lim) begin
                        steps_d = abort_lim[STEP_W-1:0];
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        timer_val = period_d - CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            dir_q    <= 1'b0;
            pmin_q   <= START_P;
            period_q <= START_P;
            accel_q  <= '0;
            steps_q  <= '0;
        end else begin
            state_q  <= state_d;
            dir_q    <= dir_d;
            pmin_q   <= pmin_d;
            period_q <= period_d;
            accel_q  <= accel_d;
            steps_q  <= steps_d;
        end
    end

    assign cmd.cmd_ready = (state_q == ST_IDLE);
    assign step_pulse    = step;
    assign dir_out       = dir_q;
    assign busy          = running;
    assign done          = (state_q == ST_DONE);
    assign steps_left    = steps_q;

endmodule
